// File: rtl/step_counter.sv
// Programmable up/down step counter with start/stop/one-shot run control.
// Feeds the downstream register's data input; tc flags wraps and one-shot completion.
module step_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MAX   = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             oneshot,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             flag_q, flag_d;
  logic             step;
  logic             at_end;

  // A step is dropped whenever load or stop claims the same edge.
  assign step   = (state_q == StRun) && en && !load && !stop;
  assign at_end = up ? (q_q == MaxVal) : (q_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      q_q     <= '0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      tc_q    <= tc_d;
      busy_q  <= busy_d;
      flag_q  <= flag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    flag_d  = flag_q;
    if (stop) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_d = StRun;
            flag_d  = oneshot;
          end
        end
        StRun: begin
          if (step && at_end && flag_q) state_d = StDone;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;
    if (load) begin
      // Zero-extend before comparing so the check stays meaningful when MAX is all ones.
      q_d = (32'(load_val) > MAX) ? MaxVal : load_val;
    end else if (step) begin
      if (at_end) begin
        tc_d = 1'b1;
        if (!flag_q) q_d = up ? '0 : MaxVal;
      end else begin
        q_d = up ? q_q + WIDTH'(1) : q_q - WIDTH'(1);
      end
    end
    busy_d = (state_d == StRun);
  end

  assign q    = q_q;
  assign tc   = tc_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_step_counter.sv
// Scoreboard bench for step_counter: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against a MAX=15 and a MAX=9 instance.
module tb_step_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0, start = 1'b0, stop = 1'b0, oneshot = 1'b0;
  logic       en = 1'b0, up = 1'b0, load = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] q15, q9;
  logic       tc15, tc9, busy15, busy9;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    string      name;
    bit         sel9;
    logic [3:0] q;
    logic       tc;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  always #5 clk = ~clk;

  step_counter #(.WIDTH(4), .MAX(15)) dut15 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .oneshot(oneshot), .en(en),
    .up(up), .load(load), .load_val(load_val), .q(q15), .tc(tc15), .busy(busy15)
  );

  step_counter #(.WIDTH(4), .MAX(9)) dut9 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .oneshot(oneshot), .en(en),
    .up(up), .load(load), .load_val(load_val), .q(q9), .tc(tc9), .busy(busy9)
  );

  task automatic expect_out(input string name, input bit sel9, input logic [3:0] eq,
                            input logic etc, input logic eb);
    exp_t x;
    x.name = name; x.sel9 = sel9; x.q = eq; x.tc = etc; x.busy = eb;
    exp_q.push_back(x);
  endtask

  // Advance one edge, record what must be visible after it, then release pulse inputs.
  task automatic tick(input string name, input bit sel9, input logic [3:0] eq,
                      input logic etc, input logic eb);
    @(posedge clk);
    #1;
    expect_out(name, sel9, eq, etc, eb);
    start = 1'b0; stop = 1'b0; load = 1'b0; reset = 1'b0;
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [3:0] aq;
      logic       atc, ab;
      e   = exp_q.pop_front();
      aq  = e.sel9 ? q9 : q15;
      atc = e.sel9 ? tc9 : tc15;
      ab  = e.sel9 ? busy9 : busy15;
      total_cnt++;
      if (aq === e.q && atc === e.tc && ab === e.busy) pass_cnt++;
      else $display("FAIL %s: got q=%0d tc=%b busy=%b, want q=%0d tc=%b busy=%b",
                    e.name, aq, atc, ab, e.q, e.tc, e.busy);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset beats a simultaneous load.
    reset = 1; load = 1; load_val = 7;
    tick("reset", 0, 0, 0, 0);
    expect_out("reset9", 1, 0, 0, 0);

    // Continuous wrap upward.
    start = 1; oneshot = 0; up = 1; en = 1;
    tick("start_wrap", 0, 0, 0, 1);
    for (int i = 1; i <= 17; i++) tick("wrap_up", 0, 4'(i % 16), (i == 16), 1);

    // One-shot down to DONE.
    stop = 1; en = 0;
    tick("stop_run", 0, 1, 0, 0);
    load = 1; load_val = 2;
    tick("load2", 0, 2, 0, 0);
    start = 1; oneshot = 1; up = 0; en = 1;
    tick("start_os", 0, 2, 0, 1);
    tick("os_dn1", 0, 1, 0, 1);
    tick("os_dn0", 0, 0, 0, 1);
    tick("os_done", 0, 0, 1, 0);
    tick("done_hold", 0, 0, 0, 0);

    // en/up ignored in DONE, then restart, then ignored in IDLE.
    for (int i = 0; i < 6; i++) begin
      en = (i % 2) == 1; up = (i % 4) >= 2;
      tick("gate_done", 0, 0, 0, 0);
    end
    start = 1; oneshot = 0; en = 0;
    tick("restart_from_done", 0, 0, 0, 1);
    stop = 1;
    tick("stop_idle", 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      en = (i % 2) == 0; up = i[0];
      tick("gate_idle", 0, 0, 0, 0);
    end
    start = 1; stop = 1; en = 1;
    tick("stop_beats_start", 0, 0, 0, 0);

    // Load outranks step; stop outranks a terminal step.
    load = 1; load_val = 5; en = 0;
    tick("load5", 0, 5, 0, 0);
    start = 1; up = 1; oneshot = 0;
    tick("start_pri", 0, 5, 0, 1);
    en = 1; load = 1; load_val = 12;
    tick("load_over_step", 0, 12, 0, 1);
    tick("step13", 0, 13, 0, 1);
    tick("step14", 0, 14, 0, 1);
    tick("step15", 0, 15, 0, 1);
    stop = 1;
    tick("stop_at_max", 0, 15, 0, 0);
    tick("idle_after_stop", 0, 15, 0, 0);

    // Load on a would-be wrap drops the tc; direction changes apply immediately.
    start = 1; en = 0;
    tick("start_at_max", 0, 15, 0, 1);
    en = 1; load = 1; load_val = 3;
    tick("load_drops_tc", 0, 3, 0, 1);
    up = 0;
    tick("dir_down", 0, 2, 0, 1);
    up = 1;
    tick("dir_up", 0, 3, 0, 1);

    // start in RUN must not re-latch oneshot: the count still wraps.
    start = 1; oneshot = 1; up = 0;
    tick("start_in_run", 0, 2, 0, 1);
    tick("dn1", 0, 1, 0, 1);
    tick("dn0", 0, 0, 0, 1);
    tick("wrap_dn", 0, 15, 1, 1);
    tick("after_wrap_dn", 0, 14, 0, 1);

    // Reset on the edge of a would-be wrap cancels the tc.
    load = 1; load_val = 0;
    tick("load0_run", 0, 0, 0, 1);
    reset = 1;
    tick("reset_at_term", 0, 0, 0, 0);

    // Saturating load and modulo-(MAX+1) wrap on the MAX=9 instance.
    load = 1; load_val = 14; en = 0;
    tick("sat9", 1, 9, 0, 0);
    expect_out("load14_max15", 0, 14, 0, 0);
    start = 1; oneshot = 0; up = 1;
    tick("start9", 1, 9, 0, 1);
    en = 1;
    tick("wrap9", 1, 0, 1, 1);
    tick("after_wrap9", 1, 1, 0, 1);
    up = 0;
    tick("dn9", 1, 0, 0, 1);
    tick("wrap_dn9", 1, 9, 1, 1);

    en = 0;
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/step_counter.md
# step_counter

Programmable 4-bit up/down step counter that drives the data input of the downstream 4-bit `flop` register stage. The counter steps on qualified enable ticks, wraps or stops at a programmable terminal value, and supports parallel load. A small run-control state machine handles start/stop/one-shot operation. Its `q` output feeds the register's `d` directly, and its `tc` pulse is available to downstream toggle logic.

## Interface
Parameters:
- `WIDTH`, 4: counter width. Matches the downstream register data width.
- `MAX`, 15: terminal count. Legal range 1..2^WIDTH-1. Count range is 0..MAX.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: begin counting; `oneshot` is sampled on the same edge.
- `stop`, in, 1: halt counting and return to IDLE.
- `oneshot`, in, 1: 1 = stop at the terminal value; 0 = wrap continuously.
- `en`, in, 1: step qualifier. One step per cycle with `en`=1 while in RUN.
- `up`, in, 1: direction, 1 = increment, 0 = decrement. Sampled on every step.
- `load`, in, 1: parallel load request.
- `load_val`, in, WIDTH: value to load.
- `q`, out, WIDTH: current count. Connects to the downstream register `d`.
- `tc`, out, 1: one-cycle registered pulse on a wrap or on DONE entry.
- `busy`, out, 1: high while in RUN.

## Operation
- States: IDLE, RUN, DONE. Encoding is free; the state is registered.
- Reset (synchronous, highest priority) sets:
  - state = IDLE
  - `q` = 0, `tc` = 0, `busy` = 0
  - latched one-shot flag = 0
- Transitions:
  - IDLE/DONE → RUN when `start`=1 and `stop`=0. The one-shot flag latches `oneshot` at this edge.
  - RUN → IDLE on `stop`=1.
  - RUN → DONE on a one-shot terminal step (see below).
  - `stop` and `start` together: `stop` wins. State goes or stays IDLE.
  - `start` while already in RUN is ignored; the one-shot flag is not re-latched.
- Load:
  - Accepted in any state. `q` ← `load_val`, saturated to MAX if `load_val` > MAX.
  - Load does not change state.
  - Load outranks stepping: a step coinciding with a load is dropped and produces no `tc`.
- Step (RUN, `en`=1, no `load`, no `stop`):
  - `up`=1, `q` < MAX: `q` ← `q`+1.
  - `up`=1, `q` == MAX:
    - flag = 0: `q` ← 0 (wrap), `tc` pulse.
    - flag = 1: `q` holds MAX, state ← DONE, `tc` pulse.
  - `up`=0, `q` > 0: `q` ← `q`-1.
  - `up`=0, `q` == 0:
    - flag = 0: `q` ← MAX (wrap), `tc` pulse.
    - flag = 1: `q` holds 0, state ← DONE, `tc` pulse.
- No stepping in IDLE or DONE. `en` is ignored there.
- Arithmetic is modulo (MAX+1), never 2^WIDTH. `q` must never exceed MAX.
- `busy` = 1 exactly while state is RUN, and is registered alongside the state.

## Timing
- Single clock domain, no combinational input-to-output paths. `q`, `tc` and `busy` are all flop outputs.
- Latency:
  - `start` at edge N: `busy`=1 after edge N. The first step can occur at edge N+1.
  - Step or load at edge N: the new `q` is visible after edge N. The downstream register captures it at edge N+1.
  - `tc` is high for exactly the one cycle following the wrap/DONE edge, then returns to 0.
- Reset mid-count: `q`, `tc` and `busy` are 0 after the reset edge regardless of the other inputs, and any pending `tc` is cancelled.
- `stop` on the same edge as a terminal step: `stop` wins. No step, no `tc`, state IDLE.
- Direction change between steps takes effect on the next step, with no dead cycle.

## Test plan
- **Reset:** assert `reset` for 1 cycle with `load`=1, `load_val`=7.
  - Required: `q`=0, `busy`=0, `tc`=0.
- **Wrap up:** `start`, `oneshot`=0, `up`=1, `en`=1 for 17 cycles, MAX=15.
  - Required: `q` runs 1..15, 0, 1. `tc` is high for one cycle only, after the 15→0 edge.
- **One-shot down:** `load_val`=2, `load`, then `start` with `oneshot`=1, `up`=0, `en`=1 for 5 cycles.
  - Required: `q` = 1, 0, 0, 0. State is DONE, `busy`=0 after the 0-terminal edge, and `tc` pulses once.
- **Priority:** in RUN at `q`=5, assert `load`=1 (`load_val`=12) and `en`=1 together.
  - Required: `q`=12, no step.
  - Then at `q`=15, assert `stop` and `en` together: `q` stays 15, `tc`=0, state IDLE.
- **Load saturation:** MAX=9, `load_val`=14.
  - Required: `q`=9. The next up-step wraps to 0 with a `tc` pulse.
- **Gating:** toggle `en` randomly in IDLE and in DONE.
  - Required: `q` does not change. A `start` from DONE re-enters RUN with `busy`=1 on the next cycle.
